rr_mux_stream: RTL and testbench

- Parametrised successor to the combinational 8:1 mux tree: NUM_CH-input, WIDTH-bit streaming multiplexer with per-channel valid/ready handshake.
- Selects among requesting channels by round-robin or fixed priority, chosen at runtime.
- Registers the selected word into one output stage.
- Sits between datapath producers and a single shared consumer, such as a shared memory write port or a result bus.

---
 rtl/rr_mux_stream_pkg.sv | 12 +
 rtl/rr_mux_stream_rr_arbiter.sv | 41 ++++
 rtl/rr_mux_stream.sv | 102 ++++++++++
 tb/tb_rr_mux_stream.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_stream_pkg.sv
// Shared constants and helpers for the round-robin streaming mux.
package rr_mux_stream_pkg;

   localparam logic MODE_RR    = 1'b0;
   localparam logic MODE_FIXED = 1'b1;

   // Index width that never collapses to zero bits.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_mux_stream_rr_arbiter.sv
// Combinational arbiter: round-robin from a pointer or fixed lowest-index priority.
module rr_arbiter
   import rr_mux_stream_pkg::*;
#(
   parameter int unsigned NUM_CH = 8,
   parameter int unsigned SEL_W  = idx_w(NUM_CH)
) (
   input  logic [NUM_CH-1:0] i_req,
   input  logic [SEL_W-1:0]  i_ptr,
   input  logic              i_mode,
   output logic [NUM_CH-1:0] o_gnt,
   output logic [SEL_W-1:0]  o_idx,
   output logic              o_any
);

   // Scan from farthest to nearest candidate so the nearest requester wins.
   always_comb begin
      int unsigned j;
      logic [SEL_W-1:0] w_cand;
      o_gnt  = '0;
      o_idx  = '0;
      o_any  = |i_req;
      j      = 0;
      w_cand = '0;
      if (i_mode == MODE_FIXED) begin
         for (int i = NUM_CH - 1; i >= 0; i--) begin
            w_cand = SEL_W'(i);
            if (i_req[w_cand]) o_idx = w_cand;
         end
      end else begin
         for (int k = NUM_CH - 1; k >= 0; k--) begin
            j = 32'(i_ptr) + 32'(k);
            if (j >= NUM_CH) j = j - NUM_CH;
            w_cand = SEL_W'(j);
            if (i_req[w_cand]) o_idx = w_cand;
         end
      end
      o_gnt[o_idx] = o_any;
   end

endmodule

// File: rtl/rr_mux_stream.sv
// NUM_CH:1 streaming mux with runtime round-robin / fixed-priority selection
// and a single registered output stage.
// Optional packet locking: define RR_MUX_STREAM_PACKET_LOCK_EN.
module rr_mux_stream
   import rr_mux_stream_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned NUM_CH = 8,
   parameter int unsigned SEL_W  = idx_w(NUM_CH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_CH*WIDTH-1:0] in_data,
   input  logic [NUM_CH-1:0]       in_valid,
`ifdef RR_MUX_STREAM_PACKET_LOCK_EN
   input  logic [NUM_CH-1:0]       in_last,
`endif
   output logic [NUM_CH-1:0]       in_ready,
   input  logic                    mode,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_sel,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_last
);

   logic [WIDTH-1:0]  r_out_data;
   logic [SEL_W-1:0]  r_out_sel;
   logic              r_out_valid;
   logic [SEL_W-1:0]  r_rr_ptr;
   logic [NUM_CH-1:0] w_req;
   logic [NUM_CH-1:0] w_gnt;
   logic [SEL_W-1:0]  w_idx;
   logic              w_any;
   logic              w_load;
   logic              w_xfer;
   logic [SEL_W-1:0]  w_ptr_nxt;

   assign w_load    = ~r_out_valid | out_ready;
   assign w_xfer    = w_any & w_load & ~rst;
   assign w_ptr_nxt = (w_idx == SEL_W'(NUM_CH - 1)) ? '0 : w_idx + SEL_W'(1);

`ifdef RR_MUX_STREAM_PACKET_LOCK_EN
   logic r_lock;
   logic r_out_last;

   // While a packet is open only the channel that owns it may be granted.
   assign w_req    = r_lock ? (in_valid & (NUM_CH'(1) << r_out_sel)) : in_valid;
   assign out_last = r_out_last;
`else
   assign w_req    = in_valid;
   assign out_last = 1'b0;
`endif

   rr_arbiter #(
      .NUM_CH (NUM_CH),
      .SEL_W  (SEL_W)
   ) u_arb (
      .i_req  (w_req),
      .i_ptr  (r_rr_ptr),
      .i_mode (mode),
      .o_gnt  (w_gnt),
      .o_idx  (w_idx),
      .o_any  (w_any)
   );

   assign in_ready = (w_load & ~rst) ? w_gnt : '0;

   // Output stage: capture the granted word, drain when empty, hold on stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_data  <= '0;
         r_out_sel   <= '0;
         r_out_valid <= 1'b0;
         r_rr_ptr    <= '0;
`ifdef RR_MUX_STREAM_PACKET_LOCK_EN
         r_lock      <= 1'b0;
         r_out_last  <= 1'b0;
`endif
      end else if (w_load) begin
         if (w_xfer) begin
            r_out_data  <= in_data[w_idx*WIDTH +: WIDTH];
            r_out_sel   <= w_idx;
            r_out_valid <= 1'b1;
`ifdef RR_MUX_STREAM_PACKET_LOCK_EN
            r_lock      <= ~in_last[w_idx];
            r_out_last  <= in_last[w_idx];
            if (in_last[w_idx]) r_rr_ptr <= w_ptr_nxt;
`else
            r_rr_ptr    <= w_ptr_nxt;
`endif
         end else begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_data  = r_out_data;
   assign out_sel   = r_out_sel;
   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_rr_mux_stream.sv
// Directed bench for rr_mux_stream (8 channels, 8-bit data).
module tb_rr_mux_stream;

   logic        clk;
   logic        rst;
   logic [63:0] in_data;
   logic [7:0]  in_valid;
   logic [7:0]  in_ready;
   logic        mode;
   logic [7:0]  out_data;
   logic [2:0]  out_sel;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
`ifdef RR_MUX_STREAM_PACKET_LOCK_EN
   logic [7:0]  in_last;
`endif

   int vec;
   int errs;

   rr_mux_stream #(.WIDTH(8), .NUM_CH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
`ifdef RR_MUX_STREAM_PACKET_LOCK_EN
      .in_last   (in_last),
`endif
      .in_ready  (in_ready),
      .mode      (mode),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst = 1'b1; mode = 1'b0; out_ready = 1'b1; in_valid = 8'hFF;
      for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = 8'(8'h10 + i);
`ifdef RR_MUX_STREAM_PACKET_LOCK_EN
      in_last = 8'h00;
`endif
      repeat (2) @(negedge clk);
      #1;
      vec++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 3'd0 || out_last !== 1'b0) begin
         errs++;
         $display("FAIL reset_state: got v=%b d=%h s=%0d l=%b, want v=0 d=00 s=0 l=0",
                  out_valid, out_data, out_sel, out_last);
      end
      vec++;
      if (in_ready !== 8'h00) begin
         errs++;
         $display("FAIL reset_no_ready: got %h want 00", in_ready);
      end
      @(negedge clk);
      rst = 1'b0; in_valid = 8'h00;
      @(negedge clk);
   endtask

   task automatic test_rr_sweep();
      int ch;
      mode = 1'b0; out_ready = 1'b1; in_valid = 8'hFF;
      #1;
      vec++;
      if (out_valid !== 1'b0) begin
         errs++;
         $display("FAIL rr_first_latency: out_valid got %b want 0", out_valid);
      end
      for (int k = 0; k < 9; k++) begin
         ch = k % 8;
         vec++;
         if (in_ready !== (8'h01 << ch)) begin
            errs++;
            $display("FAIL rr_ready[%0d]: got %h want %h", k, in_ready, 8'h01 << ch);
         end
         @(negedge clk); #1;
         vec++;
         if (out_valid !== 1'b1 || out_sel !== 3'(ch) || out_data !== 8'(8'h10 + ch)) begin
            errs++;
            $display("FAIL rr_out[%0d]: got v=%b s=%0d d=%h want v=1 s=%0d d=%h",
                     k, out_valid, out_sel, out_data, ch, 8'(8'h10 + ch));
         end
      end
      in_valid = 8'h00;
      @(negedge clk); #1;
      vec++;
      if (out_valid !== 1'b0) begin
         errs++;
         $display("FAIL rr_drain: out_valid got %b want 0", out_valid);
      end
   endtask

   task automatic test_fixed();
      mode = 1'b1; in_valid = 8'b1010_0100;
      #1;
      for (int k = 0; k < 4; k++) begin
         vec++;
         if (in_ready !== 8'h04) begin
            errs++;
            $display("FAIL fixed_ready[%0d]: got %h want 04", k, in_ready);
         end
         @(negedge clk); #1;
         vec++;
         if (out_valid !== 1'b1 || out_sel !== 3'd2 || out_data !== 8'h12) begin
            errs++;
            $display("FAIL fixed_out[%0d]: got v=%b s=%0d d=%h want v=1 s=2 d=12",
                     k, out_valid, out_sel, out_data);
         end
      end
   endtask

   task automatic test_wrap();
      int seq [3];
      seq[0] = 6; seq[1] = 3; seq[2] = 6;
      mode = 1'b0; in_valid = 8'h08;
      #1;
      vec++;
      if (in_ready !== 8'h08) begin
         errs++;
         $display("FAIL wrap_setup: got %h want 08", in_ready);
      end
      @(negedge clk);
      in_valid = 8'h48;
      #1;
      for (int k = 0; k < 3; k++) begin
         vec++;
         if (in_ready !== (8'h01 << seq[k])) begin
            errs++;
            $display("FAIL wrap_ready[%0d]: got %h want %h", k, in_ready, 8'h01 << seq[k]);
         end
         @(negedge clk); #1;
         vec++;
         if (out_sel !== 3'(seq[k]) || out_valid !== 1'b1) begin
            errs++;
            $display("FAIL wrap_out[%0d]: got s=%0d v=%b want s=%0d v=1",
                     k, out_sel, out_valid, seq[k]);
         end
      end
   endtask

   task automatic test_stall();
      in_data[8 +: 8] = 8'hA5;
      in_valid = 8'h02; out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0; in_valid = 8'h06;
      #1;
      for (int k = 0; k < 5; k++) begin
         vec++;
         if (in_ready !== 8'h00 || out_valid !== 1'b1 || out_data !== 8'hA5 || out_sel !== 3'd1) begin
            errs++;
            $display("FAIL stall_hold[%0d]: got r=%h v=%b d=%h s=%0d want r=00 v=1 d=a5 s=1",
                     k, in_ready, out_valid, out_data, out_sel);
         end
         @(negedge clk); #1;
      end
      out_ready = 1'b1;
      #1;
      vec++;
      if (in_ready !== 8'h04) begin
         errs++;
         $display("FAIL stall_release_ready: got %h want 04", in_ready);
      end
      @(negedge clk);
      in_valid = 8'h00;
      #1;
      vec++;
      if (out_valid !== 1'b1 || out_sel !== 3'd2 || out_data !== 8'h12) begin
         errs++;
         $display("FAIL stall_next_word: got v=%b s=%0d d=%h want v=1 s=2 d=12",
                  out_valid, out_sel, out_data);
      end
      @(negedge clk); #1;
      vec++;
      if (out_valid !== 1'b0) begin
         errs++;
         $display("FAIL stall_no_dup: out_valid got %b want 0", out_valid);
      end
   endtask

   task automatic test_reset_mid();
      in_valid = 8'h10; out_ready = 1'b1;
      @(negedge clk);
      rst = 1'b1; in_valid = 8'hFF; out_ready = 1'b0;
      #1;
      vec++;
      if (in_ready !== 8'h00) begin
         errs++;
         $display("FAIL rst_mid_ready: got %h want 00", in_ready);
      end
      @(negedge clk); #1;
      vec++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 3'd0) begin
         errs++;
         $display("FAIL rst_mid_clear: got v=%b d=%h s=%0d want v=0 d=00 s=0",
                  out_valid, out_data, out_sel);
      end
      rst = 1'b0; out_ready = 1'b1;
      #1;
      vec++;
      if (in_ready !== 8'h01) begin
         errs++;
         $display("FAIL rst_mid_ptr: got %h want 01", in_ready);
      end
      @(negedge clk); #1;
      vec++;
      if (out_valid !== 1'b1 || out_sel !== 3'd0 || out_data !== 8'h10) begin
         errs++;
         $display("FAIL rst_mid_restart: got v=%b s=%0d d=%h want v=1 s=0 d=10",
                  out_valid, out_sel, out_data);
      end
      in_valid = 8'h00;
      @(negedge clk);
   endtask

`ifdef RR_MUX_STREAM_PACKET_LOCK_EN
   task automatic test_packet_lock();
      logic [7:0] lasts [3];
      lasts[0] = 8'h00; lasts[1] = 8'h00; lasts[2] = 8'h02;
      mode = 1'b1; out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_valid = (k == 0) ? 8'h02 : 8'h07;
         in_last  = lasts[k];
         #1;
         vec++;
         if (in_ready !== 8'h02) begin
            errs++;
            $display("FAIL lock_ready[%0d]: got %h want 02", k, in_ready);
         end
         @(negedge clk); #1;
         vec++;
         if (out_sel !== 3'd1 || out_last !== (k == 2)) begin
            errs++;
            $display("FAIL lock_out[%0d]: got s=%0d l=%b want s=1 l=%b", k, out_sel, out_last, k == 2);
         end
      end
      in_last = 8'h00;
      #1;
      vec++;
      if (in_ready !== 8'h01) begin
         errs++;
         $display("FAIL lock_release: got %h want 01", in_ready);
      end
      in_valid = 8'h00;
      @(negedge clk);
   endtask
`endif

   initial begin
      vec = 0;
      errs = 0;
      test_reset();
      test_rr_sweep();
      test_fixed();
      test_wrap();
      test_stall();
      test_reset_mid();
`ifdef RR_MUX_STREAM_PACKET_LOCK_EN
      test_packet_lock();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
